// File: rtl/can_cmd_pkg.sv
// Shared types for the CAN command master.
//   BUS_W   : width of the CAN-controller register bus (address and data)
//   state_t : master FSM states
//   cmd_t   : one queued command {write, addr, wdat}
package can_cmd_pkg;

  localparam int BUS_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2,
    GAP   = 2'd3
  } state_t;

  typedef struct packed {
    logic             write;
    logic [BUS_W-1:0] addr;
    logic [BUS_W-1:0] wdat;
  } cmd_t;

endpackage

// File: rtl/can_cmd_fifo.sv
// Command queue for the CAN command master.
//   sysclk, rstn : clock, asynchronous active-low reset
//   push / din   : write one command (ignored when full)
//   pop  / dout  : dout shows the head entry; pop discards it (ignored when empty)
//   full, empty  : registered status flags
// Pointers wrap modulo DEPTH (power of two). There is no bypass path, so a
// command written into an empty queue is first visible one cycle later.
module can_cmd_fifo
  import can_cmd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic sysclk,
  input  logic rstn,
  input  logic push,
  input  logic pop,
  input  cmd_t din,
  output cmd_t dout,
  output logic full,
  output logic empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

  cmd_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  // Storage carries no reset: entries are only read once written.
  always_ff @(posedge sysclk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge sysclk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_nxt;
      full  <= (count_nxt == CNT_FULL);
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/can_cmd_master.sv
// Queued register-access master for a CAN controller CPU port.
//   cmd_*  : command input, valid/ready handshake
//   rsp_*  : one-cycle response strobe with held rdat/err/timeout
//   cpu_*  : CAN-controller register bus (cs/read/write/addr/wdat out,
//            rdat/ack/err in)
//   busy   : queue non-empty or FSM not IDLE
// Handshake: a command is taken on any rising edge where cmd_valid and
// cmd_ready are both 1; cmd_ready is simply !full of the queue and never
// looks at a pop in the same cycle. The response side has no backpressure.
// Transaction flow: IDLE pops -> ISSUE (cs high until ack/err/timeout)
// -> RESP (rsp_valid) -> GAP -> IDLE.
module can_cmd_master
  import can_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic             sysclk,
  input  logic             rstn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [BUS_W-1:0] cmd_addr,
  input  logic [BUS_W-1:0] cmd_wdat,
  output logic             rsp_valid,
  output logic [BUS_W-1:0] rsp_rdat,
  output logic             rsp_err,
  output logic             rsp_timeout,
  output logic             cpu_cs,
  output logic             cpu_read,
  output logic             cpu_write,
  output logic [BUS_W-1:0] cpu_addr,
  output logic [BUS_W-1:0] cpu_wdat,
  input  logic [BUS_W-1:0] cpu_rdat,
  input  logic             cpu_ack,
  input  logic             cpu_err,
  output logic             busy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // Last ISSUE cycle that may still be acked; cs stays high TIMEOUT_CYC cycles.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  cmd_t             fifo_din;
  cmd_t             fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;

  assign fifo_din  = '{write: cmd_write, addr: cmd_addr, wdat: cmd_wdat};
  assign pop       = (state == IDLE) && !fifo_empty;
  assign cmd_ready = !fifo_full;
  assign busy      = !fifo_empty || (state != IDLE);

  can_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sysclk (sysclk),
    .rstn   (rstn),
    .push   (cmd_valid && cmd_ready),
    .pop    (pop),
    .din    (fifo_din),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_ff @(posedge sysclk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      cnt         <= '0;
      cpu_cs      <= 1'b0;
      cpu_read    <= 1'b0;
      cpu_write   <= 1'b0;
      cpu_addr    <= '0;
      cpu_wdat    <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdat    <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            cpu_addr  <= fifo_dout.addr;
            cpu_wdat  <= fifo_dout.wdat;
            cpu_write <= fifo_dout.write;
            cpu_read  <= !fifo_dout.write;
            cpu_cs    <= 1'b1;
            cnt       <= '0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          // Leaves ISSUE no later than CNT_LAST, so this never passes TIMEOUT_CYC.
          cnt <= cnt + CNT_ONE;
          if (cpu_ack || cpu_err) begin
            // Error wins over a simultaneous ack; read data only on a clean read.
            rsp_rdat    <= (cpu_read && !cpu_err) ? cpu_rdat : '0;
            rsp_err     <= cpu_err;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            cpu_cs      <= 1'b0;
            cpu_read    <= 1'b0;
            cpu_write   <= 1'b0;
            state       <= RESP;
          end else if (cnt == CNT_LAST) begin
            rsp_rdat    <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            cpu_cs      <= 1'b0;
            cpu_read    <= 1'b0;
            cpu_write   <= 1'b0;
            state       <= RESP;
          end
        end
        RESP:    state <= GAP;
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_can_cmd_master.sv
// Directed testbench for can_cmd_master: a vector table of single
// transactions plus hand-written sequences for queue fill, stray acks and
// reset in the middle of ISSUE.
module tb_can_cmd_master;

  logic        sysclk;
  logic        rstn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdat;
  logic        rsp_valid;
  logic [31:0] rsp_rdat;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        cpu_cs;
  logic        cpu_read;
  logic        cpu_write;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdat;
  logic [31:0] cpu_rdat;
  logic        cpu_ack;
  logic        cpu_err;
  logic        busy;

  can_cmd_master #(
    .FIFO_DEPTH  (4),
    .TIMEOUT_CYC (255)
  ) dut (
    .sysclk      (sysclk),
    .rstn        (rstn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdat    (cmd_wdat),
    .rsp_valid   (rsp_valid),
    .rsp_rdat    (rsp_rdat),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .cpu_cs      (cpu_cs),
    .cpu_read    (cpu_read),
    .cpu_write   (cpu_write),
    .cpu_addr    (cpu_addr),
    .cpu_wdat    (cpu_wdat),
    .cpu_rdat    (cpu_rdat),
    .cpu_ack     (cpu_ack),
    .cpu_err     (cpu_err),
    .busy        (busy)
  );

  // ---------------- clock / reset ----------------
  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge sysclk);
    #1;
  endtask

  task automatic push_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
    check1("push_ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdat  = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdat;
    int          ack_at;   // ISSUE cycle that carries ack/err, 0 = never
    logic        ack;
    logic        err;
    logic [31:0] rdat;
    int          exp_cs;
    logic [31:0] exp_rdat;
    logic        exp_err;
    logic        exp_to;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs[NV];

  task automatic run_vector(input int idx);
    vec_t v;
    int   cs_cycles;
    logic stable_ok;
    logic dir_ok;
    v = vecs[idx];
    push_cmd(v.write, v.addr, v.wdat);
    check1($sformatf("v%0d_cs_low_n1", idx), cpu_cs, 1'b0);
    tick();
    check1($sformatf("v%0d_cs_high_n2", idx), cpu_cs, 1'b1);
    cs_cycles = 0;
    stable_ok = 1'b1;
    dir_ok    = 1'b1;
    while (cpu_cs === 1'b1 && cs_cycles < 400) begin
      cs_cycles++;
      if (cpu_addr !== v.addr || cpu_wdat !== v.wdat) stable_ok = 1'b0;
      if (cpu_write !== v.write || cpu_read !== !v.write) dir_ok = 1'b0;
      if (cs_cycles == v.ack_at) begin
        cpu_ack  = v.ack;
        cpu_err  = v.err;
        cpu_rdat = v.rdat;
      end
      tick();
      cpu_ack  = 1'b0;
      cpu_err  = 1'b0;
      cpu_rdat = $urandom();
    end
    check32($sformatf("v%0d_cs_cycles", idx), 32'(cs_cycles), 32'(v.exp_cs));
    check1($sformatf("v%0d_addr_wdat_stable", idx), stable_ok, 1'b1);
    check1($sformatf("v%0d_direction", idx), dir_ok, 1'b1);
    check1($sformatf("v%0d_rsp_valid", idx), rsp_valid, 1'b1);
    check32($sformatf("v%0d_rsp_rdat", idx), rsp_rdat, v.exp_rdat);
    check1($sformatf("v%0d_rsp_err", idx), rsp_err, v.exp_err);
    check1($sformatf("v%0d_rsp_timeout", idx), rsp_timeout, v.exp_to);
    tick();
    check1($sformatf("v%0d_rsp_one_cycle", idx), rsp_valid, 1'b0);
    tick();
    check32($sformatf("v%0d_rsp_rdat_hold", idx), rsp_rdat, v.exp_rdat);
    check1($sformatf("v%0d_busy_done", idx), busy, 1'b0);
  endtask

  // ---------------- test ----------------
  initial begin
    int   min_gap;
    int   wait_cyc;
    logic accepted;
    logic seen;

    vecs[0] = '{1'b1, 32'h0000_0004, 32'h1234_5678,   3, 1'b1, 1'b0, 32'hDEAD_BEEF,   3, 32'h0,          1'b0, 1'b0};
    vecs[1] = '{1'b0, 32'h0000_0010, 32'h0,           1, 1'b1, 1'b0, 32'hA5A5_0001,   1, 32'hA5A5_0001,  1'b0, 1'b0};
    vecs[2] = '{1'b0, 32'h0000_0020, 32'h0,           2, 1'b0, 1'b1, 32'h1111_2222,   2, 32'h0,          1'b1, 1'b0};
    vecs[3] = '{1'b0, 32'h0000_0030, 32'h0,           1, 1'b1, 1'b1, 32'hFFFF_0000,   1, 32'h0,          1'b1, 1'b0};
    vecs[4] = '{1'b0, 32'h0000_0040, 32'h0,           0, 1'b0, 1'b0, 32'h0,         255, 32'h0,          1'b1, 1'b1};
    vecs[5] = '{1'b1, 32'h0000_0044, 32'hCAFE_0005,   4, 1'b0, 1'b1, 32'h7777_7777,   4, 32'h0,          1'b1, 1'b0};
    vecs[6] = '{1'b0, 32'h0000_0048, 32'h0,         255, 1'b1, 1'b0, 32'h0BAD_F00D, 255, 32'h0BAD_F00D,  1'b0, 1'b0};

    rstn      = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdat  = '0;
    cpu_rdat  = '0;
    cpu_ack   = 1'b0;
    cpu_err   = 1'b0;

    // reset state
    tick();
    tick();
    check1("rst_cs", cpu_cs, 1'b0);
    check1("rst_read", cpu_read, 1'b0);
    check1("rst_write", cpu_write, 1'b0);
    check32("rst_addr", cpu_addr, 32'h0);
    check32("rst_wdat", cpu_wdat, 32'h0);
    check1("rst_rsp_valid", rsp_valid, 1'b0);
    check32("rst_rsp_rdat", rsp_rdat, 32'h0);
    check1("rst_rsp_err", rsp_err, 1'b0);
    check1("rst_rsp_timeout", rsp_timeout, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_cmd_ready", cmd_ready, 1'b1);
    rstn = 1'b1;
    tick();

    for (int i = 0; i < NV; i++) run_vector(i);

    // stray ack/err while idle
    seen = 1'b0;
    cpu_ack = 1'b1;
    cpu_err = 1'b1;
    cpu_rdat = 32'h5555_AAAA;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rsp_valid !== 1'b0 || cpu_cs !== 1'b0) seen = 1'b1;
    end
    cpu_ack = 1'b0;
    cpu_err = 1'b0;
    tick();
    check1("stray_no_rsp", seen, 1'b0);
    check1("stray_rsp_err_held", rsp_err, 1'b0);
    check32("stray_rsp_rdat_held", rsp_rdat, 32'h0BAD_F00D);

    // queue fill: hold the FSM in ISSUE, then offer five commands
    push_cmd(1'b0, 32'h0000_0100, 32'h0);
    exp_q.push_back(32'h0000_0100);
    tick();
    check1("fill_first_issue", cpu_cs, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      check1($sformatf("fill_ready_%0d", i), cmd_ready, 1'b1);
      cmd_valid = 1'b1;
      cmd_write = 1'(i % 2);
      cmd_addr  = 32'h0000_0100 + 32'(4 * i);
      cmd_wdat  = 32'hC0DE_0000 + 32'(i);
      exp_q.push_back(cmd_addr);
      tick();
    end
    cmd_addr  = 32'h0000_0114;
    cmd_wdat  = 32'hC0DE_0005;
    cmd_write = 1'b1;
    check1("fill_full_ready_low", cmd_ready, 1'b0);
    check1("fill_full_busy", busy, 1'b1);
    tick();
    check1("fill_fifth_held", cmd_ready, 1'b0);
    exp_q.push_back(32'h0000_0114);

    accepted = 1'b0;
    min_gap  = 1000;
    fork
      begin
        wait_cyc = 0;
        while (cmd_ready !== 1'b1 && wait_cyc < 100) begin
          tick();
          wait_cyc++;
        end
        tick();
        cmd_valid = 1'b0;
        accepted  = (wait_cyc < 100);
      end
      begin
        for (int t = 0; t < 6; t++) begin
          int          low;
          logic [31:0] exp_a;
          low = 0;
          while (cpu_cs !== 1'b1 && low < 50) begin
            tick();
            low++;
          end
          if (t > 0 && low < min_gap) min_gap = low;
          exp_a = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
          check32($sformatf("fill_order_%0d", t), cpu_addr, exp_a);
          cpu_ack  = 1'b1;
          cpu_rdat = 32'h0;
          tick();
          cpu_ack = 1'b0;
          check1($sformatf("fill_rsp_%0d", t), rsp_valid, 1'b1);
          tick();
        end
      end
    join
    check1("fill_fifth_accepted", accepted, 1'b1);
    check1("fill_min_gap_ge2", (min_gap >= 2), 1'b1);
    tick();
    tick();
    check1("fill_busy_done", busy, 1'b0);

    // reset in ISSUE cycle 2 with two commands queued
    push_cmd(1'b1, 32'h0000_0200, 32'h1);
    push_cmd(1'b1, 32'h0000_0204, 32'h2);
    check1("rst_mid_issue1", cpu_cs, 1'b1);
    push_cmd(1'b0, 32'h0000_0208, 32'h3);
    check1("rst_mid_issue2", cpu_cs, 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    check1("rst_mid_cs_async", cpu_cs, 1'b0);
    check1("rst_mid_busy", busy, 1'b0);
    check1("rst_mid_cmd_ready", cmd_ready, 1'b1);
    tick();
    tick();
    rstn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rsp_valid !== 1'b0 || cpu_cs !== 1'b0) seen = 1'b1;
    end
    check1("rst_mid_no_activity", seen, 1'b0);
    check1("rst_mid_busy_after", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
